// File: rtl/exe_hazard_ctrl.sv
// rtl/exe_hazard_ctrl.sv - execute-stage forwarding/stall/flush controller; EXE_FORWARD_EN enables operand bypass
module exe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic             id_imm,
    input  logic [4:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             br_taken,
    output logic [1:0]       sel_val1,
    output logic [1:0]       sel_val2,
    output logic [1:0]       sel_imm,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       use1;
        logic       use2;
        logic       imm;
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_read;
    } shadow_t;

    shadow_t          id_e;
    shadow_t          x_q, m_q, w_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    function automatic logic is_writer(input shadow_t e);
        return e.valid && e.wb_en && (e.dest != 5'd0);
    endfunction

    // True when the ID instruction reads the register that entry e will write.
    function automatic logic id_reads(input shadow_t e, input logic [4:0] s1, input logic [4:0] s2,
                                      input logic u1, input logic u2);
        return is_writer(e) && ((u1 && (s1 == e.dest)) || (u2 && (s2 == e.dest)));
    endfunction

`ifdef EXE_FORWARD_EN
    function automatic logic [1:0] fwd(input logic [4:0] s, input logic u,
                                       input shadow_t m, input shadow_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (u) begin
            if (is_writer(m) && (m.dest == s) && !m.mem_read) begin
                sel = 2'd1;
            end else if (is_writer(w) && (w.dest == s)) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction
`endif

    always_comb begin
        id_e     = {1'b1, id_src1, id_src2, id_use_src1, id_use_src2, id_imm,
                    id_dest, id_wb_en, id_mem_read};
        sel_val1 = 2'd0;
        sel_val2 = 2'd0;
        sel_imm  = 2'd0;
        hazard   = 1'b0;
`ifdef EXE_FORWARD_EN
        // Only a load in EXE cannot be bypassed in time; everything else forwards.
        hazard = x_q.mem_read && id_reads(x_q, id_src1, id_src2, id_use_src1, id_use_src2);
        if (rst && x_q.valid) begin
            sel_val1 = fwd(x_q.src1, x_q.use1, m_q, w_q);
            sel_imm  = fwd(x_q.src2, x_q.use2, m_q, w_q);
            sel_val2 = x_q.imm ? 2'd0 : sel_imm;
        end
`else
        // Register file is read in ID and written after WB, so wait out every writer.
        hazard = id_reads(x_q, id_src1, id_src2, id_use_src1, id_use_src2)
              || id_reads(m_q, id_src1, id_src2, id_use_src1, id_use_src2)
              || id_reads(w_q, id_src1, id_src2, id_use_src1, id_use_src2);
`endif
        stall = rst && !br_taken && hazard;
        flush = rst && br_taken;
        x_d   = (stall || br_taken) ? '0 : id_e;
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            m_q   <= x_q;
            w_q   <= m_q;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

    logic unused_shadow;
    assign unused_shadow = ^{x_q, m_q, w_q};

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb/tb_exe_hazard_ctrl.sv - vector table, corner sequences and random model check for exe_hazard_ctrl
module tb_exe_hazard_ctrl;
`ifdef EXE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       use1;
        logic       use2;
        logic       imm;
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_read;
    } instr_t;

    typedef struct {
        logic       rst;
        logic       br;
        instr_t     id;
        logic [1:0] v1;
        logic [1:0] v2;
        logic [1:0] im;
        logic       st;
        logic       fl;
        int         cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       br_taken = 1'b0;
    logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic       id_use_src1 = 1'b0, id_use_src2 = 1'b0, id_imm = 1'b0;
    logic       id_wb_en = 1'b0, id_mem_read = 1'b0;
    logic [1:0] sel_val1, sel_val2, sel_imm;
    logic       stall, flush;
    logic [15:0] stall_cnt;
    logic [1:0] unused_v1_4, unused_v2_4, unused_im_4;
    logic       stall4, unused_flush4;
    logic [3:0] stall_cnt4;

    int     checks = 0;
    int     failures = 0;
    instr_t hist [3];
    instr_t cur;
    int     m_cnt = 0;
    int     m_cnt4 = 0;
    logic   m_st = 1'b0;
    vec_t   tab [$];

    exe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_imm(id_imm),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .br_taken(br_taken), .sel_val1(sel_val1), .sel_val2(sel_val2),
        .sel_imm(sel_imm), .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
    );

    exe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_imm(id_imm),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .br_taken(br_taken), .sel_val1(unused_v1_4), .sel_val2(unused_v2_4),
        .sel_imm(unused_im_4), .stall(stall4), .flush(unused_flush4), .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    function automatic instr_t ins(input int s1, input int s2, input int u1, input int u2,
                                   input int imm, input int d, input int wb, input int mr);
        instr_t i;
        i.valid = 1'b1;      i.src1 = 5'(s1);  i.src2 = 5'(s2);
        i.use1 = 1'(u1);     i.use2 = 1'(u2);  i.imm = 1'(imm);
        i.dest = 5'(d);      i.wb_en = 1'(wb); i.mem_read = 1'(mr);
        return i;
    endfunction

    function automatic vec_t vv(input int r, input int b, input instr_t i, input int v1, input int v2,
                                input int im, input int st, input int fl, input int cnt);
        vec_t v;
        v.rst = 1'(r); v.br = 1'(b); v.id = i;
        v.v1 = 2'(v1); v.v2 = 2'(v2); v.im = 2'(im);
        v.st = 1'(st); v.fl = 1'(fl); v.cnt = cnt;
        return v;
    endfunction

    function automatic logic wr(input instr_t e);
        return e.valid && e.wb_en && (e.dest != 5'd0);
    endfunction

    // Reference: hist[0]=EXE, hist[1]=MEM, hist[2]=WB; the youngest non-load producer wins.
    function automatic logic [1:0] m_fwd(input logic [4:0] s, input logic u);
        if (!FWD || !rst || !hist[0].valid || !u) return 2'd0;
        if (wr(hist[1]) && hist[1].dest == s && !hist[1].mem_read) return 2'd1;
        if (wr(hist[2]) && hist[2].dest == s) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        logic hit;
        hit = 1'b0;
        for (int a = 0; a < (FWD ? 1 : 3); a++) begin
            if (wr(hist[a]) && (hist[a].mem_read || !FWD) &&
                ((cur.use1 && cur.src1 == hist[a].dest) || (cur.use2 && cur.src2 == hist[a].dest)))
                hit = 1'b1;
        end
        return hit && rst && !br_taken;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic b, input instr_t i);
        @(negedge clk);
        rst = r; br_taken = b; cur = i;
        id_src1 = i.src1; id_src2 = i.src2; id_use_src1 = i.use1; id_use_src2 = i.use2;
        id_imm = i.imm; id_dest = i.dest; id_wb_en = i.wb_en; id_mem_read = i.mem_read;
        #1;
        m_st = m_stall();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int a = 0; a < 3; a++) hist[a] = '0;
            m_cnt = 0;
            m_cnt4 = 0;
        end else begin
            if (m_st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (m_st || br_taken) ? '0 : cur;
        end
    endtask

    task automatic check_model(input string nm);
        logic [1:0] e2;
        e2 = m_fwd(hist[0].src2, hist[0].use2);
        cmp({nm, ".sel_val1"}, 32'(sel_val1), 32'(m_fwd(hist[0].src1, hist[0].use1)));
        cmp({nm, ".sel_imm"}, 32'(sel_imm), 32'(e2));
        cmp({nm, ".sel_val2"}, 32'(sel_val2), hist[0].imm ? 32'd0 : 32'(e2));
        cmp({nm, ".stall"}, 32'(stall), 32'(m_st));
        cmp({nm, ".flush"}, 32'(flush), 32'(rst && br_taken));
        cmp({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        cmp({nm, ".stall_cnt4"}, 32'(stall_cnt4), 32'(m_cnt4));
    endtask

    task automatic check_vec(input int k);
        string nm;
        nm = $sformatf("vec%0d", k);
        cmp({nm, ".sel_val1"}, 32'(sel_val1), 32'(tab[k].v1));
        cmp({nm, ".sel_val2"}, 32'(sel_val2), 32'(tab[k].v2));
        cmp({nm, ".sel_imm"}, 32'(sel_imm), 32'(tab[k].im));
        cmp({nm, ".stall"}, 32'(stall), 32'(tab[k].st));
        cmp({nm, ".stall4"}, 32'(stall4), 32'(tab[k].st));
        cmp({nm, ".flush"}, 32'(flush), 32'(tab[k].fl));
        cmp({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(tab[k].cnt));
        cmp({nm, ".stall_cnt4"}, 32'(stall_cnt4), 32'(tab[k].cnt));
    endtask

    function automatic void fill_fwd();
        instr_t add3, sub, nop, or6, lw2, addi2, add0, sub00, lw0, addi0;
        add3 = ins(1,2,1,1,0,3,1,0);  sub   = ins(3,5,1,1,0,4,1,0);
        nop  = ins(0,0,0,0,0,0,0,0);  or6   = ins(3,3,1,1,0,6,1,0);
        lw2  = ins(1,0,1,0,1,2,1,1);  addi2 = ins(2,0,1,0,1,7,1,0);
        add0 = ins(1,2,1,1,0,0,1,0);  sub00 = ins(0,0,1,1,0,4,1,0);
        lw0  = ins(1,0,1,0,1,0,1,1);  addi0 = ins(0,0,1,0,1,7,1,0);
        tab.push_back(vv(0,1,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,sub,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,nop,  1,0,0,0,0,0));
        tab.push_back(vv(1,0,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,nop,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,or6,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,nop,  2,2,2,0,0,0));
        tab.push_back(vv(1,0,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,or6,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,nop,  1,1,1,0,0,0));
        tab.push_back(vv(1,0,lw2,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,addi2,0,0,0,1,0,0));
        tab.push_back(vv(1,0,addi2,0,0,0,0,0,1));
        tab.push_back(vv(1,0,nop,  2,0,0,0,0,1));
        tab.push_back(vv(1,0,add0, 0,0,0,0,0,1));
        tab.push_back(vv(1,0,sub00,0,0,0,0,0,1));
        tab.push_back(vv(1,0,nop,  0,0,0,0,0,1));
        tab.push_back(vv(1,0,lw0,  0,0,0,0,0,1));
        tab.push_back(vv(1,0,addi0,0,0,0,0,0,1));
        tab.push_back(vv(1,0,lw2,  0,0,0,0,0,1));
        tab.push_back(vv(1,1,addi2,0,0,0,0,1,1));
        tab.push_back(vv(1,0,nop,  0,0,0,0,0,1));
        tab.push_back(vv(1,0,lw2,  0,0,0,0,0,1));
        tab.push_back(vv(1,0,addi2,0,0,0,1,0,1));
        tab.push_back(vv(0,0,addi2,0,0,0,0,0,2));
        tab.push_back(vv(1,0,nop,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,lw2,  0,0,0,0,0,0));
        tab.push_back(vv(0,0,addi2,0,0,0,0,0,0));
        tab.push_back(vv(1,0,addi2,0,0,0,0,0,0));
    endfunction

    function automatic void fill_nofwd();
        instr_t add3, sub31, nop, add0, sub00, lw2, addi2, s22, lw5, sw5;
        add3 = ins(1,2,1,1,0,3,1,0);  sub31 = ins(3,1,1,1,0,4,1,0);
        nop  = ins(0,0,0,0,0,0,0,0);  add0  = ins(1,2,1,1,0,0,1,0);
        sub00 = ins(0,0,1,1,0,4,1,0); lw2   = ins(1,0,1,0,1,2,1,1);
        addi2 = ins(2,0,1,0,1,7,1,0); s22   = ins(2,2,1,1,0,4,1,0);
        lw5  = ins(1,0,1,0,1,5,1,1);  sw5   = ins(0,5,0,1,0,0,0,0);
        tab.push_back(vv(0,1,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,add3, 0,0,0,0,0,0));
        tab.push_back(vv(1,0,sub31,0,0,0,1,0,0));
        tab.push_back(vv(1,0,sub31,0,0,0,1,0,1));
        tab.push_back(vv(1,0,sub31,0,0,0,1,0,2));
        tab.push_back(vv(1,0,sub31,0,0,0,0,0,3));
        tab.push_back(vv(1,0,nop,  0,0,0,0,0,3));
        tab.push_back(vv(1,0,add0, 0,0,0,0,0,3));
        tab.push_back(vv(1,0,sub00,0,0,0,0,0,3));
        tab.push_back(vv(1,0,lw2,  0,0,0,0,0,3));
        tab.push_back(vv(1,1,addi2,0,0,0,0,1,3));
        tab.push_back(vv(1,0,nop,  0,0,0,0,0,3));
        tab.push_back(vv(0,0,s22,  0,0,0,0,0,3));
        tab.push_back(vv(1,0,s22,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,lw5,  0,0,0,0,0,0));
        tab.push_back(vv(1,0,sw5,  0,0,0,1,0,0));
        tab.push_back(vv(1,0,sw5,  0,0,0,1,0,1));
        tab.push_back(vv(1,0,sw5,  0,0,0,1,0,2));
        tab.push_back(vv(1,0,sw5,  0,0,0,0,0,3));
    endfunction

    function automatic instr_t rand_ins();
        return ins($urandom_range(0,5), $urandom_range(0,5), $urandom_range(0,1), $urandom_range(0,1),
                   $urandom_range(0,1), $urandom_range(0,5), $urandom_range(0,3) != 0,
                   $urandom_range(0,3) == 0);
    endfunction

    initial begin
        instr_t r_ins;
        logic   r_rst, r_br;
        bit     hold;
        for (int a = 0; a < 3; a++) hist[a] = '0;
        cur = '0;
        if (FWD) fill_fwd();
        else fill_nofwd();

        foreach (tab[k]) begin
            apply(tab[k].rst, tab[k].br, tab[k].id);
            check_vec(k);
            tick();
        end

        apply(1'b0, 1'b0, '0);
        tick();
        hold = 1'b0;
        r_ins = '0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) r_ins = rand_ins();
            r_rst = ($urandom_range(0, 31) != 0);
            r_br  = ($urandom_range(0, 9) == 0);
            apply(r_rst, r_br, r_ins);
            check_model($sformatf("rnd%0d", n));
            hold = m_st;
            tick();
        end

        apply(1'b0, 1'b0, '0);
        tick();
        for (int n = 0; n < 20; n++) begin
            apply(1'b1, 1'b0, ins(1,0,1,0,1,2,1,1));
            check_model($sformatf("sat%0d.lw", n));
            tick();
            for (int j = 0; j < 3; j++) begin
                apply(1'b1, 1'b0, ins(2,0,1,0,1,7,1,0));
                check_model($sformatf("sat%0d.addi%0d", n, j));
                tick();
            end
        end
        apply(1'b1, 1'b0, '0);
        cmp("sat.cnt4_saturated", 32'(stall_cnt4), 32'd15);
        cmp("sat.cnt16_at_least_20", 32'(stall_cnt >= 16'd20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
